// File: rtl/cic_gain_norm.sv
// Gain normaliser for the multi-channel CIC decimator output.
// A small sequential engine derives shift = ceil(N_STAGES*log2(rate)) (clamped),
// and a 2-stage pipeline applies round-half-up shift plus signed saturation.
module cic_gain_norm #(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned MAX_BIT_GAIN = 28,
  parameter int unsigned N_STAGES     = 4,
  parameter int unsigned CHANNELS     = 2
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [7:0]                                  rate,
  input  logic                                        rate_load,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic [CHANNELS*(WIDTH+MAX_BIT_GAIN)-1:0]    in_data,
  output logic                                        out_valid,
  output logic [CHANNELS*WIDTH-1:0]                   out_data,
  output logic [CHANNELS-1:0]                         out_sat,
  output logic                                        busy,
  output logic [4:0]                                  shift,
  output logic                                        gain_clipped
);

  localparam int unsigned IW = WIDTH + MAX_BIT_GAIN;       // input width per channel
  localparam int unsigned XW = IW + 1;                     // one guard bit for the rounding add
  localparam int unsigned PW = 8 * N_STAGES;               // width of R^N
  localparam int unsigned SW = $clog2(PW + 1);             // holds bit lengths 0..PW
  localparam int unsigned CW = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

  localparam logic signed [XW-1:0] SAT_HI = XW'((64'd1 << (WIDTH - 1)) - 64'd1);
  localparam logic signed [XW-1:0] SAT_LO = ~SAT_HI;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MUL,
    ST_SCAN
  } state_e;

  state_e            state_q;
  logic [7:0]        rate_q;
  logic [PW-1:0]     prod_q;
  logic [CW-1:0]     mul_cnt_q;
  logic [4:0]        shift_q;
  logic              busy_q;
  logic              clip_q;

  logic [PW-1:0]     rate_ext;
  logic [PW-1:0]     prod_m1;
  logic [SW-1:0]     blen;
  logic              blen_clip;

  logic              accept;
  logic signed [XW-1:0] rnd;
  logic signed [XW-1:0] x_ext [CHANNELS];
  logic signed [XW-1:0] xr_d  [CHANNELS];

  logic              s1_valid_q;
  logic signed [XW-1:0] s1_x_q [CHANNELS];

  logic [CHANNELS*WIDTH-1:0] data_d;
  logic [CHANNELS-1:0]       sat_d;

  logic                      out_valid_q;
  logic [CHANNELS*WIDTH-1:0] out_data_q;
  logic [CHANNELS-1:0]       out_sat_q;

  assign rate_ext     = PW'(rate_q);
  assign in_ready     = ~busy_q;
  assign accept       = in_valid & ~busy_q;
  assign busy         = busy_q;
  assign shift        = shift_q;
  assign gain_clipped = clip_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_sat      = out_sat_q;

  // Bit length of (P-1), i.e. ceil(log2(P)); P=1 yields 0.
  always_comb begin
    prod_m1 = prod_q - PW'(1);
    blen    = '0;
    for (int i = 0; i < int'(PW); i++) begin
      if (prod_m1[i]) blen = SW'(i + 1);
    end
    blen_clip = (blen > SW'(MAX_BIT_GAIN));
  end

  // Shift engine: LOAD -> MUL x(N_STAGES-1) -> SCAN; a new rate_load always restarts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rate_q    <= 8'd1;
      prod_q    <= '0;
      mul_cnt_q <= '0;
      shift_q   <= 5'd0;
      busy_q    <= 1'b0;
      clip_q    <= 1'b0;
    end else if (rate_load) begin
      rate_q    <= (rate == 8'd0) ? 8'd1 : rate;
      mul_cnt_q <= '0;
      busy_q    <= 1'b1;
      state_q   <= ST_LOAD;
    end else begin
      case (state_q)
        ST_LOAD: begin
          prod_q    <= rate_ext;
          mul_cnt_q <= '0;
          state_q   <= (N_STAGES > 1) ? ST_MUL : ST_SCAN;
        end
        ST_MUL: begin
          prod_q <= prod_q * rate_ext;
          if (mul_cnt_q == CW'(N_STAGES - 2)) begin
            state_q <= ST_SCAN;
          end else begin
            mul_cnt_q <= mul_cnt_q + CW'(1);
          end
        end
        ST_SCAN: begin
          shift_q <= blen_clip ? 5'(MAX_BIT_GAIN) : 5'(blen);
          clip_q  <= blen_clip;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Rounding constant 2^(shift-1), or zero when no shift is applied.
  always_comb begin
    rnd = '0;
    if (shift_q != 5'd0) rnd = XW'(1) << (shift_q - 5'd1);
  end

  // Stage 1 datapath: sign-extend by one bit, round, arithmetic shift.
  always_comb begin
    for (int c = 0; c < int'(CHANNELS); c++) begin
      x_ext[c] = signed'({in_data[c*IW + IW - 1], in_data[c*IW +: IW]});
      xr_d[c]  = (x_ext[c] + rnd) >>> shift_q;
    end
  end

  // Stage 1 register: sample is captured with the shift in effect at acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      for (int c = 0; c < int'(CHANNELS); c++) s1_x_q[c] <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        for (int c = 0; c < int'(CHANNELS); c++) s1_x_q[c] <= xr_d[c];
      end
    end
  end

  // Stage 2 datapath: saturate each channel to the signed output range.
  always_comb begin
    data_d = '0;
    sat_d  = '0;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      if (s1_x_q[c] > SAT_HI) begin
        data_d[c*WIDTH +: WIDTH] = {1'b0, {(WIDTH-1){1'b1}}};
        sat_d[c]                 = 1'b1;
      end else if (s1_x_q[c] < SAT_LO) begin
        data_d[c*WIDTH +: WIDTH] = {1'b1, {(WIDTH-1){1'b0}}};
        sat_d[c]                 = 1'b1;
      end else begin
        data_d[c*WIDTH +: WIDTH] = s1_x_q[c][WIDTH-1:0];
      end
    end
  end

  // Output register: data and flags hold between valid pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= '0;
    end else begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_data_q <= data_d;
        out_sat_q  <= sat_d;
      end
    end
  end

endmodule
